axis_gemv_fixed_mac_seq: RTL
============================

// Module: axis_gemv_fixed_mac_seq
// PURPOSE
//  Sequences one signed DATA_W x DATA_W multiplier (comb, 0-stage) plus accumulator to compute GEMV rows.
//  Consumes AXIS (a,x) operand pairs; s_axis_tlast ends a row. Emits one rounded, saturated dot product per row.
//  A cfg_start/done handshake frames a job of cfg_rows rows. Sits between the operand fetch stream and result writeback.
// PARAMETERS
//  DATA_W  25  operand width, signed two's complement, FRAC_W fractional bits
//  FRAC_W  16  fractional bits per operand; product carries 2*FRAC_W
//  ACC_W   64  accumulator width, signed
//  OUT_W   32  result width, signed, FRAC_W fractional bits
// PORTS
//  ap_clk          in   1         clock
//  ap_rst          in   1         synchronous reset, active-high
//  cfg_start       in   1         1-cycle job start pulse; sampled only in IDLE
//  cfg_rows        in   16        rows in job; captured on accepted cfg_start
//  s_axis_tdata    in   2*DATA_W  [DATA_W-1:0]=a, [2*DATA_W-1:DATA_W]=x
//  s_axis_tvalid   in   1         operand beat valid
//  s_axis_tlast    in   1         last beat of current row
//  s_axis_tready   out  1         operand beat accepted when valid&ready
//  m_axis_tdata    out  OUT_W     row result
//  m_axis_tvalid   out  1         result valid
//  m_axis_tlast    out  1         high with the last row of the job
//  m_axis_tready   in   1         downstream ready
//  busy            out  1         high in any state except IDLE
//  done            out  1         1-cycle pulse at job completion
//  sat_flag        out  1         sticky: some row saturated this job; cleared on accepted cfg_start
// BEHAVIOUR
//  Reset: state=IDLE; acc=0; p_valid=0; row_cnt=0; all outputs 0 (tready, tvalid, tlast, busy, done, sat_flag, tdata).
//  States:
//   IDLE  cfg_start=1: capture cfg_rows, row_cnt=0, clear sat_flag. Go to DONE if cfg_rows==0, else RUN.
//   RUN   s_axis_tready = !hold, where hold sets on accepted tlast and clears on result handshake.
//         Accepted beat at edge k: p_reg=$signed(a)*$signed(x) (2*DATA_W bits), p_valid=1, p_last=tlast.
//         Edge k+1 with p_valid: sum = acc + sext(p_reg). If !p_last, acc=sum.
//           If p_last: m_axis_tdata=sat(round(sum)), m_axis_tvalid=1, acc=0.
//           m_axis_tlast = (row_cnt==cfg_rows-1). Go to OUT.
//         Latency: accepted tlast beat to m_axis_tvalid = 2 cycles.
//   OUT   Hold tdata/tvalid/tlast stable until m_axis_tready. On handshake: tvalid=0, hold=0, row_cnt++.
//         Go to DONE if row_cnt+1==cfg_rows, else RUN. tready may be high in the same cycle as tvalid.
//   DONE  done=1 for exactly one cycle, busy=0 from the next cycle, then IDLE.
//  Arithmetic:
//   round(v) = (v + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift; round half toward +inf.
//   sat: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Clamping sets sat_flag.
//   acc wraps modulo 2^ACC_W; no overflow detection inside acc.
//  Boundaries:
//   Single-beat row (tlast on first beat): result = sat(round(a*x)).
//   tvalid gaps: no effect on the accumulation.
//   cfg_start while busy: ignored, with no change to cfg_rows or sat_flag.
//   Beats presented in IDLE/OUT/DONE: not accepted (tready=0).
//   ap_rst mid-row or mid-OUT: drop the partial acc and pending result, return to reset values next cycle.
// TESTING
//  T1 Row of 2 beats, a=65536,x=131072 then a=32768,x=-65536 (tlast), rows=1
//     -> tdata=98304 (1.5), tlast=1, done pulse 1 cycle after handshake.
//  T2 rows=3 with m_axis_tready held low 5 cycles per result
//     -> tdata stable while stalled, s_axis_tready=0 during stall, 3 results, tlast only on the 3rd.
//  T3 4 beats a=x=2^24-1
//     -> tdata=0x7FFFFFFF, sat_flag=1. Next job's cfg_start clears sat_flag.
//  T4 Rounding: a=1,x=32768 -> 1 (half up); a=-1,x=32768 -> 0; a=-1,x=32769 -> -1.
//  T5 cfg_rows=0 -> done pulse, no m_axis_tvalid. cfg_start pulsed during RUN -> ignored.
//  T6 ap_rst after 3 beats of a row, then new job with a 1-beat row a=65536,x=65536
//     -> tdata=65536 (no residue in acc).

Source files
------------

// File: rtl/axis_gemv_fixed_mac_seq.sv
// Sequenced GEMV row engine: one signed multiplier feeding a wrapping accumulator,
// emitting one rounded, saturated fixed-point dot product per AXIS row.
module axis_gemv_fixed_mac_seq #(
    parameter int DATA_W = 25,
    parameter int FRAC_W = 16,
    parameter int ACC_W  = 64,
    parameter int OUT_W  = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                cfg_start,
    input  logic [15:0]         cfg_rows,
    input  logic [2*DATA_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [OUT_W-1:0]    m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                done,
    output logic                sat_flag,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

    state_t state, state_nxt;

    logic [15:0]             rows_r;
    logic [15:0]             row_cnt;
    logic [ACC_W-1:0]        acc;
    logic [2*DATA_W-1:0]     p_reg;
    logic                    p_valid;
    logic                    p_last;
    logic                    hold;

    logic [2*DATA_W-1:0]     prod;
    logic [ACC_W-1:0]        p_ext;
    logic [ACC_W-1:0]        sum;
    logic signed [ACC_W-1:0] rnd;
    logic [ACC_W-OUT_W:0]    upper;
    logic                    sat_hit;
    logic [OUT_W-1:0]        sat_val;
    logic                    beat_acc;
    logic                    out_hs;

    // Both streams transfer a beat on a clock edge where valid and ready are both high;
    // a source holds its data stable while valid is high and ready is low.
    assign beat_acc = s_axis_tvalid && s_axis_tready;
    assign out_hs   = m_axis_tvalid && m_axis_tready;

    assign prod = $signed({{DATA_W{s_axis_tdata[DATA_W-1]}}, s_axis_tdata[DATA_W-1:0]})
                * $signed({{DATA_W{s_axis_tdata[2*DATA_W-1]}}, s_axis_tdata[2*DATA_W-1:DATA_W]});

    assign p_ext = {{(ACC_W-2*DATA_W){p_reg[2*DATA_W-1]}}, p_reg};
    assign sum   = acc + p_ext;
    assign rnd   = $signed(sum + HALF) >>> FRAC_W;

    // Fits in OUT_W only when every bit above the result's sign bit matches it.
    assign upper   = rnd[ACC_W-1:OUT_W-1];
    assign sat_hit = !((&upper) || !(|upper));
    assign sat_val = !sat_hit       ? rnd[OUT_W-1:0] :
                     rnd[ACC_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                      {1'b0, {(OUT_W-1){1'b1}}};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cfg_start) state_nxt = (cfg_rows == 16'd0) ? S_DONE : S_RUN;
            S_RUN:  if (p_valid && p_last) state_nxt = S_OUT;
            S_OUT:  if (out_hs) state_nxt = (row_cnt + 16'd1 == rows_r) ? S_DONE : S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state == S_RUN) && !hold;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        dbg_state     = state;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rows_r        <= '0;
            row_cnt       <= '0;
            acc           <= '0;
            p_reg         <= '0;
            p_valid       <= 1'b0;
            p_last        <= 1'b0;
            hold          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            if (state == S_IDLE && cfg_start) begin
                rows_r   <= cfg_rows;
                row_cnt  <= '0;
                sat_flag <= 1'b0;
                acc      <= '0;
                hold     <= 1'b0;
            end

            p_valid <= beat_acc;
            if (beat_acc) begin
                p_reg  <= prod;
                p_last <= s_axis_tlast;
                if (s_axis_tlast) hold <= 1'b1;
            end

            // The product registered last edge folds in now, overlapping the next beat's multiply.
            if (p_valid) begin
                if (!p_last) begin
                    acc <= sum;
                end else begin
                    acc           <= '0;
                    m_axis_tdata  <= sat_val;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= (row_cnt == rows_r - 16'd1);
                    if (sat_hit) sat_flag <= 1'b1;
                end
            end

            if (out_hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                hold          <= 1'b0;
                row_cnt       <= row_cnt + 16'd1;
            end
        end
    end

endmodule
